// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter sharing one downstream valid/ready port among four requesters.
// Grants are registered and held for up to MAX_BEATS beats or until the owner drops its request.
module rr_mux_arbiter_4 #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [3:0]            req_i,
  input  logic [DATA_WIDTH-1:0] data0_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  input  logic [DATA_WIDTH-1:0] data2_i,
  input  logic [DATA_WIDTH-1:0] data3_i,
  output logic [3:0]            ack_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [1:0]            select_o,
  output logic [3:0]            grant_o,
  output logic                  busy_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] MAX_B = 8'(MAX_BEATS);

  state_t                state_q, state_d;
  logic [1:0]            select_q, select_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [3:0]            grant_q, grant_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [3:0]            rot_req;
  logic [1:0]            offset;
  logic [1:0]            winner;
  logic                  beat;
  logic [DATA_WIDTH-1:0] data_arr [4];

  assign data_arr[0] = data0_i;
  assign data_arr[1] = data1_i;
  assign data_arr[2] = data2_i;
  assign data_arr[3] = data3_i;

  assign data_o   = data_arr[select_q];
  assign valid_o  = (state_q == GRANT) & req_i[select_q];
  assign ack_o    = grant_q & {4{ready_i}};
  assign select_o = select_q;
  assign grant_o  = grant_q;
  assign busy_o   = (state_q == GRANT);
  assign beat     = valid_o & ready_i;

  // rot_req[i] is the request sitting i+1 places after the last-granted pointer
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_req[gi] = req_i[ptr_q + 2'(gi + 1)];
    end
  endgenerate

  always_comb begin
    offset = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (rot_req[i]) offset = 2'(i);
    end
    winner = ptr_q + offset + 2'd1;
  end

  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d  = GRANT;
          select_d = winner;
          grant_d  = 4'b0001 << winner;
          cnt_d    = 8'd0;
        end
      end
      GRANT: begin
        if (!req_i[select_q] || (beat && (cnt_q + 8'd1 == MAX_B))) begin
          state_d = IDLE;
          grant_d = 4'b0000;
          ptr_d   = select_q;
          cnt_d   = 8'd0;
        end else if (beat) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      select_q <= 2'd0;
      ptr_q    <= 2'd3;
      grant_q  <= 4'b0000;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Bench for rr_mux_arbiter_4: a MAX_BEATS=4 and a MAX_BEATS=1 instance share stimulus,
// each checked every cycle against an ownership model, plus directed literal checks.
module tb_rr_mux_arbiter_4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic        ready;
  logic [31:0] din [4];

  logic [3:0]  ack_a, grant_a, ack_b, grant_b;
  logic [31:0] data_a, data_b;
  logic        valid_a, busy_a, valid_b, busy_b;
  logic [1:0]  select_a, select_b;

  int checks   = 0;
  int failures = 0;

  // model state, index 0 = MAX_BEATS 4, index 1 = MAX_BEATS 1
  int owner [2] = '{-1, -1};
  int taken [2] = '{0, 0};
  int lastp [2] = '{3, 3};
  int selm  [2] = '{0, 0};
  int maxb  [2] = '{4, 1};
  bit mvalid = 1'b0;

  int         beats_seen [2] = '{0, 0};
  logic [3:0] prev_g [2] = '{4'b0, 4'b0};
  logic [3:0] glog_a [$];
  logic [3:0] glog_b [$];

  always #5 clk = ~clk;

  rr_mux_arbiter_4 #(.DATA_WIDTH(32), .MAX_BEATS(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .data0_i(din[0]), .data1_i(din[1]), .data2_i(din[2]), .data3_i(din[3]),
    .ack_o(ack_a), .data_o(data_a), .valid_o(valid_a), .ready_i(ready),
    .select_o(select_a), .grant_o(grant_a), .busy_o(busy_a)
  );

  rr_mux_arbiter_4 #(.DATA_WIDTH(32), .MAX_BEATS(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .data0_i(din[0]), .data1_i(din[1]), .data2_i(din[2]), .data3_i(din[3]),
    .ack_o(ack_b), .data_o(data_b), .valid_o(valid_b), .ready_i(ready),
    .select_o(select_b), .grant_o(grant_b), .busy_o(busy_b)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic cmp_dut(input int d, input logic [3:0] g, input logic [1:0] s, input logic b,
                         input logic v, input logic [3:0] a, input logic [31:0] dat);
    logic [3:0] eg;
    logic       ev;
    eg = (owner[d] < 0) ? 4'b0000 : 4'(1 << owner[d]);
    ev = (owner[d] >= 0) && req[owner[d]];
    chk($sformatf("m%0d_grant", d), 64'(g), 64'(eg));
    chk($sformatf("m%0d_select", d), 64'(s), 64'(selm[d]));
    chk($sformatf("m%0d_busy", d), 64'(b), 64'(owner[d] >= 0));
    chk($sformatf("m%0d_valid", d), 64'(v), 64'(ev));
    chk($sformatf("m%0d_ack", d), 64'(a), 64'((ready && owner[d] >= 0) ? eg : 4'b0000));
    chk($sformatf("m%0d_data", d), 64'(dat), 64'(din[selm[d]]));
  endtask

  // Ownership model: who holds the port, how many beats taken, who went last
  initial begin : model
    int pick;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          owner[d] = -1; taken[d] = 0; lastp[d] = 3; selm[d] = 0;
        end else if (owner[d] < 0) begin
          if (req != 4'b0000) begin
            pick = 0;
            for (int k = 4; k >= 1; k--) begin
              if (req[(lastp[d] + k) % 4]) pick = (lastp[d] + k) % 4;
            end
            owner[d] = pick; selm[d] = pick; taken[d] = 0;
          end
        end else if (!req[owner[d]]) begin
          lastp[d] = owner[d]; owner[d] = -1;
        end else if (ready) begin
          taken[d]++;
          if (taken[d] == maxb[d]) begin
            lastp[d] = owner[d]; owner[d] = -1;
          end
        end
      end
      if (rst) mvalid = 1'b1;
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (mvalid) begin
        cmp_dut(0, grant_a, select_a, busy_a, valid_a, ack_a, data_a);
        cmp_dut(1, grant_b, select_b, busy_b, valid_b, ack_b, data_b);
        if (valid_a && ready) beats_seen[0]++;
        if (valid_b && ready) beats_seen[1]++;
        if (grant_a != 4'b0 && prev_g[0] == 4'b0) glog_a.push_back(grant_a);
        if (grant_b != 4'b0 && prev_g[1] == 4'b0) glog_b.push_back(grant_b);
        prev_g[0] = grant_a;
        prev_g[1] = grant_b;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    cyc();
    rst = 1'b0;
  endtask

  initial begin : main
    int b0;
    logic [3:0] seq4 [5];
    logic [3:0] seq1 [4];
    seq4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seq1 = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
    din  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    rst = 1'b1; req = 4'b0000; ready = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_grant", 64'(grant_a), 64'h0);
    chk("rst_busy", 64'(busy_a), 64'h0);
    chk("rst_select", 64'(select_a), 64'h0);
    chk("rst_valid", 64'(valid_a), 64'h0);

    // single requester, 4 beats per 5 cycles
    b0 = beats_seen[0];
    req = 4'b0001; ready = 1'b1;
    cyc();
    chk("s1_first_grant", 64'(grant_a), 64'h1);
    repeat (9) cyc();
    chk("s1_beats", 64'(beats_seen[0] - b0), 64'd8);
    chk("s1_bubble_grant", 64'(grant_a), 64'h0);

    // all requesting: rotate 0,1,2,3,0
    do_reset();
    glog_a.delete();
    req = 4'b1111;
    repeat (22) cyc();
    chk("s2_grant_count", 64'(glog_a.size()), 64'd5);
    for (int i = 0; i < 5 && i < glog_a.size(); i++)
      chk($sformatf("s2_grant%0d", i), 64'(glog_a[i]), 64'(seq4[i]));

    // downstream stall on requester 2
    do_reset();
    req = 4'b0100; ready = 1'b0;
    cyc();
    chk("s3_grant", 64'(grant_a), 64'h4);
    b0 = beats_seen[0];
    repeat (7) cyc();
    chk("s3_stall_ack", 64'(ack_a), 64'h0);
    chk("s3_stall_valid", 64'(valid_a), 64'h1);
    chk("s3_stall_beats", 64'(beats_seen[0] - b0), 64'd0);
    chk("s3_stall_grant", 64'(grant_a), 64'h4);
    chk("s3_data", 64'(data_a), 64'h3333_3333);
    ready = 1'b1;
    #1;
    chk("s3_ack", 64'(ack_a), 64'h4);
    repeat (4) cyc();
    chk("s3_beats", 64'(beats_seen[0] - b0), 64'd4);
    chk("s3_release", 64'(grant_a), 64'h0);

    // requester 1 drops after two beats
    do_reset();
    req = 4'b0010; ready = 1'b1;
    cyc();
    chk("s4_grant", 64'(grant_a), 64'h2);
    b0 = beats_seen[0];
    repeat (2) cyc();
    chk("s4_beats", 64'(beats_seen[0] - b0), 64'd2);
    req = 4'b0001;
    cyc();
    chk("s4_release", 64'(grant_a), 64'h0);
    chk("s4_select_hold", 64'(select_a), 64'h1);
    req = 4'b0011;
    cyc();
    chk("s4_regrant", 64'(grant_a), 64'h1);

    // reset in the middle of a burst
    do_reset();
    req = 4'b1000; ready = 1'b1;
    cyc();
    chk("s5_grant", 64'(grant_a), 64'h8);
    cyc();
    rst = 1'b1;
    cyc();
    chk("s5_rst_grant", 64'(grant_a), 64'h0);
    chk("s5_rst_busy", 64'(busy_a), 64'h0);
    chk("s5_rst_select", 64'(select_a), 64'h0);
    rst = 1'b0; req = 4'b1001;
    cyc();
    chk("s5_regrant", 64'(grant_a), 64'h1);

    // MAX_BEATS=1 alternation
    do_reset();
    glog_b.delete();
    b0 = beats_seen[1];
    req = 4'b0110; ready = 1'b1;
    repeat (8) cyc();
    chk("s6_grant_count", 64'(glog_b.size()), 64'd4);
    for (int i = 0; i < 4 && i < glog_b.size(); i++)
      chk($sformatf("s6_grant%0d", i), 64'(glog_b[i]), 64'(seq1[i]));
    chk("s6_beats", 64'(beats_seen[1] - b0), 64'd4);

    req = 4'b0000;
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter_4.md
Name: rr_mux_arbiter_4

Overview:
- Round-robin arbiter that shares one downstream data port among four requesters.
- Owns the 2-bit select of the shared 4:1 datapath multiplexer; drives it from a registered grant.
- Per-requester valid/ready handshake upstream, single valid/ready port downstream.
- Bounded burst length per grant for fairness; sits between producer units and a single consumer (e.g. write-back or memory port).

Parameters:
- DATA_WIDTH, 32, width of each data input and data_o.
- MAX_BEATS, 4, max transfers per grant before forced release; legal range 1..255.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- req_i  input  4  requester k has a valid beat (acts as valid_k).
- data0_i  input  DATA_WIDTH  requester 0 data.
- data1_i  input  DATA_WIDTH  requester 1 data.
- data2_i  input  DATA_WIDTH  requester 2 data.
- data3_i  input  DATA_WIDTH  requester 3 data.
- ack_o  output  4  per-requester ready; beat of k consumed when req_i[k] & ack_o[k].
- data_o  output  DATA_WIDTH  selected requester data.
- valid_o  output  1  downstream valid.
- ready_i  input  1  downstream ready.
- select_o  output  2  registered mux select (index of granted requester).
- grant_o  output  4  registered one-hot grant; 0 when idle.
- busy_o  output  1  high in GRANT state.

Behaviour:
- Clocking: one clock, clk_i; reset rst_i is synchronous, active-high.
- Reset values: state=IDLE, select_o=0, grant_o=0, busy_o=0, beat counter=0, last-grant pointer=3 (so requester 0 has first priority). valid_o=0 and ack_o=0 follow combinationally.
- FSM states: IDLE, GRANT.
- IDLE transition: if req_i!=0 at the edge, grant the first set bit searching (ptr+1, ptr+2, ptr+3, ptr) mod 4. Register select_o/grant_o, set busy_o, clear the beat counter, go to GRANT. Otherwise stay in IDLE.
- Latency: request sampled at edge N gives grant_o/select_o visible after edge N; earliest transfer in that same following cycle.
- GRANT datapath, all combinational:
  - data_o = data<select_o>_i.
  - valid_o = req_i[select_o].
  - ack_o = grant_o & {4{ready_i}}.
- Beat: valid_o & ready_i. Each beat increments the counter (8-bit).
- Release from GRANT to IDLE at the edge where either:
  - a beat occurs and counter+1 == MAX_BEATS, or
  - req_i[select_o]==0 (requester dropped; no beat that cycle).
- On release: ptr = select_o, grant_o=0, busy_o=0. select_o holds its last value. One IDLE bubble cycle always precedes the next grant.
- Requests from non-granted requesters never affect the current grant; they are only evaluated in IDLE.
- Downstream stall (ready_i=0 with valid_o=1) holds state, counter and grant indefinitely; no timeout.
- Simultaneous requests in IDLE: strict round-robin from ptr+1. A requester just released has lowest priority next arbitration.
- Data_o while idle: equals data<select_o>_i, don't-care to consumers since valid_o=0.
- Reset asserted mid-burst: next edge forces reset values. The in-flight beat in that cycle is not counted; upstream must treat ack_o as deasserted.
- Counter never exceeds MAX_BEATS-1 while in GRANT.

Test Plan:
- Reset then req_i=4'b0001, ready_i=1 for 10 cycles -> grant_o=0001 one cycle after the sample. Exactly 4 beats; release; 1 idle cycle; regrant 0001. Pattern repeats (4 beats per 5 cycles after the first grant).
- req_i=4'b1111 constant, ready_i=1 -> grants in order 0001,0010,0100,1000,0001. Each gives 4 beats; data_o matches data0..3 per select_o 0,1,2,3.
- Grant to requester 2, ready_i=0 for 7 cycles then 1 -> valid_o=1, ack_o=0000, counter stays 0 during the stall. Afterwards 4 beats complete with ack_o=0100.
- Grant to requester 1, requester drops req_i[1] after 2 beats -> release that edge, ptr=1. With req_i=4'b0011 pending, next grant is 0001 (0 after 1, wrapping via 2,3).
- rst_i=1 on the cycle of beat 2 of a burst -> next cycle grant_o=0, busy_o=0, select_o=0. The following arbitration with req_i=4'b1001 grants 0001.
- MAX_BEATS=1 instance with req_i=4'b0110 -> alternating grants 0010,0100 with 1 beat each and 1 idle cycle between.
